// File: rtl/conv_encoder_tx.sv
// conv_encoder_tx
//   Transmit-side rate-1/2 convolutional encoder.
//   - Takes one data bit per cycle over a valid/ready handshake.
//   - Produces one registered 2-bit code symbol for each accepted bit.
//   - Groups data into frames of FRAME_LEN bits. After each frame it appends K-1 zero tail
//     bits, so the decoder trellis starts and ends in state 0.
//
// Ports
//   clk               rising-edge clock
//   rst               asynchronous reset, active high
//   encoder_i         data bit, sampled when enable_encoder_i && ready_o
//   enable_encoder_i  input valid
//   ready_o           encoder accepts a data bit this cycle (low during the tail)
//   encoder_o         code symbol {c0,c1}; c0 uses G0 and c1 uses G1
//   valid_o           encoder_o carries a new symbol (one cycle per symbol)
//   sof_o             with valid_o: first symbol of a frame
//   eof_o             with valid_o: last tail symbol of a frame
//   busy_o            a frame is in progress (FSM not IDLE)
//   word_ct           data bits accepted since reset, wraps mod 2^CNT_W
module conv_encoder_tx #(
  parameter int             K         = 3,
  parameter logic [K-1:0]   G0        = 3'b111,
  parameter logic [K-1:0]   G1        = 3'b101,
  parameter int             FRAME_LEN = 256,
  parameter int             CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             encoder_i,
  input  logic             enable_encoder_i,
  output logic             ready_o,
  output logic [1:0]       encoder_o,
  output logic             valid_o,
  output logic             sof_o,
  output logic             eof_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] word_ct
);

  // Tail counter only needs to reach K-2.
  localparam int TW = (K > 2) ? $clog2(K - 1) : 1;
  localparam logic [TW-1:0]    TAIL_LAST  = TW'(K - 2);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  state_t           state_q, state_d;
  logic [K-2:0]     sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] word_ct_q, word_ct_d;
  logic [TW-1:0]    tail_q, tail_d;
  logic [1:0]       sym_q, sym_d;
  logic             valid_q, valid_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;

  logic             ready;
  logic             accept;
  logic             enc_bit;
  logic [K-1:0]     enc_vec;
  logic [1:0]       enc_sym;
  logic [K-2:0]     sr_shift;

  assign ready   = (state_q != TAIL);
  assign accept  = enable_encoder_i && ready;

  // During the tail the encoder is fed zeros, whatever is on encoder_i.
  assign enc_bit  = (state_q == TAIL) ? 1'b0 : encoder_i;
  assign enc_vec  = {enc_bit, sr_q};
  assign enc_sym  = {^(enc_vec & G0), ^(enc_vec & G1)};
  // The upper K-1 bits of the vector are exactly the shifted state {b, sr[K-2:1]}.
  assign sr_shift = enc_vec[K-1:1];

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    word_ct_d = word_ct_q;
    tail_d    = tail_q;
    sym_d     = sym_q;
    valid_d   = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;

    unique case (state_q)
      IDLE, DATA: begin
        if (accept) begin
          sr_d      = sr_shift;
          sym_d     = enc_sym;
          valid_d   = 1'b1;
          sof_d     = (state_q == IDLE);
          word_ct_d = word_ct_q + 1'b1;
          // cnt_q is 0 in IDLE, so a one-bit frame goes straight to the tail.
          if (cnt_q == FRAME_LAST) begin
            state_d = TAIL;
            cnt_d   = cnt_q;
          end else begin
            state_d = DATA;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      TAIL: begin
        sr_d    = sr_shift;
        sym_d   = enc_sym;
        valid_d = 1'b1;
        if (tail_q == TAIL_LAST) begin
          eof_d   = 1'b1;
          state_d = IDLE;
          tail_d  = '0;
          cnt_d   = '0;
          sr_d    = '0;
        end else begin
          tail_d  = tail_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      word_ct_q <= '0;
      tail_q    <= '0;
      sym_q     <= 2'b00;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      word_ct_q <= word_ct_d;
      tail_q    <= tail_d;
      sym_q     <= sym_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
    end
  end

  assign ready_o   = ready;
  assign busy_o    = (state_q != IDLE);
  assign encoder_o = sym_q;
  assign valid_o   = valid_q;
  assign sof_o     = sof_q;
  assign eof_o     = eof_q;
  assign word_ct   = word_ct_q;

endmodule

// File: tb/tb_conv_encoder_tx.sv
// tb_conv_encoder_tx
//   Bench for conv_encoder_tx with FRAME_LEN=4 and a 4-bit word counter, so the wrap is
//   reachable. A reference model checks every output on every falling edge. The model
//   computes each symbol as a convolution of the frame's bit history with the generators.
//   Hand-computed symbol lists pin down the directed cases.
module tb_conv_encoder_tx;
  localparam int           K  = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;
  localparam int           FL = 4;
  localparam int           CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          encoder_i = 1'b0;
  logic          enable_encoder_i = 1'b0;
  logic          ready_o;
  logic [1:0]    encoder_o;
  logic          valid_o;
  logic          sof_o;
  logic          eof_o;
  logic          busy_o;
  logic [CW-1:0] word_ct;

  conv_encoder_tx #(.K(K), .G0(G0), .G1(G1), .FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .encoder_i(encoder_i), .enable_encoder_i(enable_encoder_i),
    .ready_o(ready_o), .encoder_o(encoder_o), .valid_o(valid_o), .sof_o(sof_o),
    .eof_o(eof_o), .busy_o(busy_o), .word_ct(word_ct)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [K-1:0] g0_v = G0;
  logic [K-1:0] g1_v = G1;
  logic         hist[$];          // bits of the current frame, tail zeros included
  int           nbits = 0;        // data bits accepted in the current frame
  int           ntail = 0;        // tail symbols emitted
  int           m_word = 0;
  logic         m_valid = 1'b0;
  logic         m_sof = 1'b0;
  logic         m_eof = 1'b0;
  logic [1:0]   m_sym = 2'b00;

  // Symbol for the newest bit: c = XOR over j of g[K-1-j] & bit[n-j]; bits before the frame are 0.
  function automatic logic [1:0] conv_sym();
    logic c0 = 1'b0;
    logic c1 = 1'b0;
    int   n  = hist.size() - 1;
    for (int j = 0; j < K; j++) begin
      if (n - j >= 0) begin
        c0 = c0 ^ (g0_v[K-1-j] & hist[n-j]);
        c1 = c1 ^ (g1_v[K-1-j] & hist[n-j]);
      end
    end
    return {c0, c1};
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      hist.delete();
      nbits = 0; ntail = 0; m_word = 0;
      m_valid = 1'b0; m_sof = 1'b0; m_eof = 1'b0; m_sym = 2'b00;
    end else if (nbits == FL) begin
      hist.push_back(1'b0);
      m_sym = conv_sym();
      m_valid = 1'b1; m_sof = 1'b0;
      ntail++;
      m_eof = (ntail == K - 1);
      if (m_eof) begin
        hist.delete();
        nbits = 0;
        ntail = 0;
      end
    end else if (enable_encoder_i) begin
      hist.push_back(encoder_i);
      m_sym = conv_sym();
      m_valid = 1'b1; m_sof = (nbits == 0); m_eof = 1'b0;
      nbits++;
      m_word = (m_word + 1) % (1 << CW);
    end else begin
      m_valid = 1'b0; m_sof = 1'b0; m_eof = 1'b0;
    end
  end

  // ---------------- compare + symbol log ----------------
  logic [1:0] got_sym[$];
  logic       got_sof[$];
  logic       got_eof[$];
  int         got_cyc[$];
  int         cyc = 0;
  int         ready_low = 0;

  initial forever begin
    @(negedge clk);
    cyc++;
    chk("valid_o", valid_o, m_valid);
    chk("ready_o", ready_o, (nbits != FL));
    chk("busy_o", busy_o, (nbits > 0));
    chk("sof_o", sof_o, m_sof);
    chk("eof_o", eof_o, m_eof);
    chk("word_ct", word_ct, m_word);
    if (m_valid || rst) chk("encoder_o", encoder_o, m_sym);
    if (valid_o) begin
      got_sym.push_back(encoder_o);
      got_sof.push_back(sof_o);
      got_eof.push_back(eof_o);
      got_cyc.push_back(cyc);
      $display("sym %0d: encoder_o=%b sof=%b eof=%b word_ct=%0d", got_sym.size() - 1,
               encoder_o, sof_o, eof_o, word_ct);
    end
    if (!ready_o) ready_low++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_log();
    got_sym.delete(); got_sof.delete(); got_eof.delete(); got_cyc.delete();
    ready_low = 0;
  endtask

  task automatic send(input logic b);
    int n = 0;
    enable_encoder_i = 1'b1;
    encoder_i = b;
    while (!ready_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("send_ready_timeout", ready_o, 1'b1);
    @(posedge clk); #1;
    enable_encoder_i = 1'b0;
    encoder_i = 1'b0;
  endtask

  task automatic idle(input int n);
    enable_encoder_i = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #4 rst = 1'b0;
    @(posedge clk); #1;
    clear_log();
  endtask

  // Six symbols packed MSB first: symbol i is e[11-2i -: 2].
  task automatic check_frame(input string nm, input int base, input logic [11:0] e);
    for (int i = 0; i < 6; i++) begin
      chk({nm, "_sym"}, got_sym[base+i], e[11-2*i -: 2]);
      chk({nm, "_sof"}, got_sof[base+i], (i == 0));
      chk({nm, "_eof"}, got_eof[base+i], (i == 5));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int nfr;
    // 1) reset held for 3 cycles, released mid-cycle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_sym", encoder_o, 2'b00);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_word", word_ct, 0);
    @(posedge clk);
    #4 rst = 1'b0;
    #1;
    chk("rel_ready", ready_o, 1'b1);
    chk("rel_valid", valid_o, 1'b0);
    chk("rel_sof_eof", {sof_o, eof_o}, 2'b00);
    @(posedge clk); #1;
    clear_log();

    // 2) impulse 1,0,0,0 -> 11,10,11,00 + 00,00
    send(1); send(0); send(0); send(0); idle(4);
    $display("impulse: %0d symbols, word_ct=%0d", got_sym.size(), word_ct);
    chk("imp_count", got_sym.size(), 6);
    check_frame("imp", 0, 12'b11_10_11_00_00_00);
    chk("imp_word", word_ct, 4);
    chk("imp_span", got_cyc[5] - got_cyc[0], 5);

    // 3) stall after bit 2: 1,1,<2 idle>,0,1 -> 11,01,01,00 + 10,11
    do_reset();
    send(1); send(1); idle(2); send(0); send(1); idle(4);
    $display("stall: %0d symbols, word_ct=%0d", got_sym.size(), word_ct);
    chk("stall_count", got_sym.size(), 6);
    check_frame("stall", 0, 12'b11_01_01_00_10_11);
    chk("stall_gap", got_cyc[2] - got_cyc[1], 3);
    chk("stall_pre", got_cyc[1] - got_cyc[0], 1);
    chk("stall_post", got_cyc[5] - got_cyc[2], 3);

    // 4) back-to-back: 3 frames of 1,1,1,1 with enable held high
    do_reset();
    for (int i = 0; i < 12; i++) send(1);
    idle(4);
    $display("b2b: %0d symbols, word_ct=%0d, ready_low=%0d", got_sym.size(), word_ct, ready_low);
    chk("b2b_count", got_sym.size(), 18);
    for (int f = 0; f < 3; f++) check_frame("b2b", 6 * f, 12'b11_01_10_10_01_11);
    chk("b2b_span", got_cyc[17] - got_cyc[0], 17);
    chk("b2b_ready_low", ready_low, 6);
    chk("b2b_word", word_ct, 12);

    // 5) reset mid-frame after bit 2, then impulse must start from a clean state
    do_reset();
    send(1); send(1);
    rst = 1'b1;
    #1;
    $display("midreset: valid_o=%b busy_o=%b word_ct=%0d", valid_o, busy_o, word_ct);
    chk("mid_valid_drop", valid_o, 1'b0);
    chk("mid_busy_drop", busy_o, 1'b0);
    chk("mid_word_clr", word_ct, 0);
    repeat (2) @(posedge clk);
    #4 rst = 1'b0;
    @(posedge clk); #1;
    clear_log();
    send(1); send(0); send(0); send(0); idle(4);
    chk("mid_count", got_sym.size(), 6);
    check_frame("mid", 0, 12'b11_10_11_00_00_00);

    // 6) word_ct wrap: 20 data bits with a 4-bit counter -> 4
    do_reset();
    for (int i = 0; i < 20; i++) send(i[0]);
    idle(4);
    $display("wrap: word_ct=%0d", word_ct);
    chk("wrap_word", word_ct, 4);
    chk("wrap_count", got_sym.size(), 30);

    // 7) random bits with random stalls, checked by the model every cycle
    do_reset();
    for (int i = 0; i < 200; i++) begin
      send(1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end
    idle(4);
    nfr = 0;
    foreach (got_eof[i]) if (got_eof[i]) nfr++;
    $display("random: %0d symbols, %0d frames, word_ct=%0d", got_sym.size(), nfr, word_ct);
    chk("rand_count", got_sym.size(), 300);
    chk("rand_frames", nfr, 50);
    chk("rand_word", word_ct, 200 % 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
